// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types for the M-stage data bridge: FSM states and bus size codes.
// The size codes are also used by the instruction-side bridge.
package dmem_bus_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dmem_bus_bridge_size_enc.sv
// Byte-enable mask to bus transfer size. Illegal masks fall back to word;
// misalignment is trapped upstream, so that case never reaches the bus.
module mem_size_enc
  import dmem_bus_bridge_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] size
);

  always_comb begin
    size = SIZE_WORD;
    case (mask)
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// M-stage load/store to split-handshake bus bridge. One bus transaction per
// access; a flushed access is drained so the bus protocol is never broken.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        read_en,
  input  logic [3:0]        write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush_except,
  input  logic              pipe_stall,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t     state, state_nxt;
  logic       flushed;
  logic       access;
  logic       latch;
  logic       capture;
  logic       kill;
  logic [3:0] mask;
  logic [1:0] size;

  assign access = (|read_en) | (|write_en);
  assign mask   = (|write_en) ? write_en : read_en;
  // A flush in the same cycle as the handshake counts as already seen.
  assign kill   = flushed | flush_except;

  mem_size_enc u_size_enc (
    .mask (mask),
    .size (size)
  );

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE:
        if (access && !flush_except) begin
          state_nxt = S_REQ;
          latch     = 1'b1;
        end
      S_REQ:
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            if (kill) state_nxt = S_IDLE;
            else begin
              state_nxt = S_DONE;
              capture   = 1'b1;
            end
          end else begin
            state_nxt = kill ? S_DRAIN : S_WAIT;
          end
        end
      S_WAIT:
        if (bus_data_ok) begin
          if (flush_except) state_nxt = S_IDLE;
          else begin
            state_nxt = S_DONE;
            capture   = 1'b1;
          end
        end else if (flush_except) begin
          state_nxt = S_DRAIN;
        end
      S_DONE:
        if (!pipe_stall || flush_except) state_nxt = S_IDLE;
      S_DRAIN:
        if (bus_data_ok) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // A new access parked behind a drain must stall; a bare drain must not.
  assign mem_stall = ((state == S_IDLE) & access & ~flush_except)
                   | (state == S_REQ)
                   | (state == S_WAIT)
                   | ((state == S_DRAIN) & access);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      flushed   <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_BYTE;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      rdata     <= '0;
    end else begin
      state   <= state_nxt;
      bus_req <= (state_nxt == S_REQ);
      if (state_nxt == S_IDLE)
        flushed <= 1'b0;
      else if (state == S_REQ && flush_except)
        flushed <= 1'b1;
      if (latch) begin
        bus_wr    <= |write_en;
        bus_size  <= size;
        bus_addr  <= addr;
        bus_wdata <= wdata;
        bus_wstrb <= write_en;
      end
      if (capture) rdata <= bus_rdata;
    end
  end

endmodule
